// File: rtl/root_driver_pkg.sv
// root_driver_pkg: shared state encoding and default sizes for the root tree driver
package root_driver_pkg;
   typedef enum logic [1:0] {IDLE, RUN, OUT, DRAIN} state_t;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/root_watchdog.sv
// root_watchdog: counts RUN cycles and flags when an evaluation has run too long
module root_watchdog import root_driver_pkg::*; #(
   parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(LIMIT + 1);
   logic [CW-1:0] cnt;
   // restart on each launch, then advance once per enabled cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + CW'(1);
   assign expired = en && (cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/root_driver.sv
// root_driver: sequences one operand triple through the root tree ST/RD handshake; ROOT_DRIVER_TIMEOUT_EN adds a watchdog abort
module root_driver import root_driver_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef ROOT_DRIVER_TIMEOUT_EN
   output logic             out_timeout,
`endif
   output logic             root_st,
   input  logic             root_rd,
   input  logic [WIDTH-1:0] root_res,
   output logic [WIDTH-1:0] root_in0,
   output logic [WIDTH-1:0] root_in1,
   output logic [WIDTH-1:0] root_in2
);
   state_t state, state_nx;
   logic alive, timed, expired, accept;
   assign in_ready = alive && state == IDLE;
   assign accept = in_valid && in_ready;
`ifdef ROOT_DRIVER_TIMEOUT_EN
   root_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .clk(clk), .rst_n(rst_n), .clr(accept), .en(state == RUN), .expired(expired)
   );
   assign out_timeout = timed;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = TIMEOUT_CYCLES == 0;
   assign expired = 1'b0;
`endif
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // next state; aborted results skip DRAIN since the tree never raised RD
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? RUN : IDLE;
         RUN:     state_nx = (root_rd || expired) ? OUT : RUN;
         OUT:     state_nx = out_ready ? (timed ? IDLE : DRAIN) : OUT;
         DRAIN:   state_nx = root_rd ? DRAIN : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // operand capture, start level, and result/abort capture; completion beats timeout
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         alive <= 1'b0;
         root_st <= 1'b0;
         root_in0 <= '0;
         root_in1 <= '0;
         root_in2 <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         timed <= 1'b0;
      end else begin
         alive <= 1'b1;
         if (accept) begin
            root_in0 <= in_a;
            root_in1 <= in_b;
            root_in2 <= in_c;
            root_st <= 1'b1;
         end
         if (state == RUN && root_rd) begin
            out_data <= root_res;
            root_st <= 1'b0;
            out_valid <= 1'b1;
         end else if (state == RUN && expired) begin
            out_data <= '0;
            root_st <= 1'b0;
            out_valid <= 1'b1;
            timed <= 1'b1;
         end
         if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
            timed <= 1'b0;
         end
      end
endmodule

// File: tb/tb_root_driver.sv
// tb_root_driver: directed checks of root_driver against a three-cycle adder child model
module tb_root_driver;
   localparam int W = 16;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0, root_rd = 1'b0;
   logic in_ready, out_valid, root_st;
   logic [W-1:0] in_a = '0, in_b = '0, in_c = '0, root_res = '0;
   logic [W-1:0] out_data, root_in0, root_in1, root_in2;
`ifdef ROOT_DRIVER_TIMEOUT_EN
   logic out_timeout;
`endif
   int checks = 0, failures = 0, hold = 1, st_cnt = 0, low_cnt = 0, viol = 0, lat = 0, nres = 0;
   bit never = 1'b0, prev_st = 1'b0;
   always #5 clk = ~clk;
   root_driver #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef ROOT_DRIVER_TIMEOUT_EN
      .out_timeout(out_timeout),
`endif
      .root_st(root_st), .root_rd(root_rd), .root_res(root_res),
      .root_in0(root_in0), .root_in1(root_in1), .root_in2(root_in2)
   );
   // child tree: RD with the sum after three ST-high cycles, RD released hold cycles after ST falls
   always @(negedge clk) begin
      if (root_st && !prev_st && root_rd) viol++;
      prev_st = root_st;
      if (!rst_n) begin
         root_rd = 1'b0;
         st_cnt = 0;
      end else if (root_st) begin
         st_cnt++;
         low_cnt = 0;
         if (st_cnt == 3 && !never) begin
            root_rd = 1'b1;
            root_res = root_in0 + root_in1 + root_in2;
         end
      end else begin
         st_cnt = 0;
         if (root_rd) begin
            low_cnt++;
            if (low_cnt >= hold) root_rd = 1'b0;
         end
      end
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      bit ok = 1'b0;
      logic rdy;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_c = c;
      for (int i = 0; i < 40 && !ok; i++) begin
         rdy = in_ready;
         tick();
         ok = rdy;
      end
      check("accept", {31'd0, ok}, 32'd1);
   endtask
   task automatic wait_valid(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n++;
         if (out_valid) break;
      end
   endtask
   task automatic wait_idle;
      for (int i = 0; i < 40 && !in_ready; i++) tick();
      check("idle", {31'd0, in_ready}, 32'd1);
   endtask
   initial begin
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_root_st", {31'd0, root_st}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {16'd0, out_data}, 32'd0);
      check("rst_root_in0", {16'd0, root_in0}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);
      // basic
      out_ready = 1'b1;
      accept(16'd1, 16'd2, 16'd3);
      in_valid = 1'b0;
      check("basic_st", {31'd0, root_st}, 32'd1);
      check("basic_in1", {16'd0, root_in1}, 32'd2);
      check("basic_in2", {16'd0, root_in2}, 32'd3);
      check("basic_busy", {31'd0, in_ready}, 32'd0);
      wait_valid(lat);
      check("basic_latency", lat, 32'd3);
      check("basic_data", {16'd0, out_data}, 32'd6);
      check("basic_st_low", {31'd0, root_st}, 32'd0);
`ifdef ROOT_DRIVER_TIMEOUT_EN
      check("basic_no_timeout", {31'd0, out_timeout}, 32'd0);
`endif
      tick();
      check("basic_valid_1cyc", {31'd0, out_valid}, 32'd0);
      check("basic_drain_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("basic_ready_back", {31'd0, in_ready}, 32'd1);
      // back-pressure
      out_ready = 1'b0;
      accept(16'h7FFF, 16'd1, 16'd0);
      in_valid = 1'b0;
      wait_valid(lat);
      check("bp_data", {16'd0, out_data}, 32'h8000);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_data_hold", {16'd0, out_data}, 32'h8000);
         check("bp_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_released", {31'd0, out_valid}, 32'd0);
      tick();
      check("bp_ready_back", {31'd0, in_ready}, 32'd1);
      // drain with a lingering RD
      hold = 4;
      accept(16'd2, 16'd2, 16'd2);
      in_valid = 1'b0;
      wait_valid(lat);
      check("drain_data", {16'd0, out_data}, 32'd6);
      in_valid = 1'b1;
      in_a = 16'd5;
      in_b = 16'd5;
      in_c = 16'd5;
      for (int i = 0; i < 10 && root_rd; i++) begin
         check("drain_ready", {31'd0, in_ready}, 32'd0);
         check("drain_st", {31'd0, root_st}, 32'd0);
         tick();
      end
      check("drain_rd_fell", {31'd0, root_rd}, 32'd0);
      check("drain_ready_back", {31'd0, in_ready}, 32'd1);
      hold = 1;
      accept(16'd5, 16'd5, 16'd5);
      in_valid = 1'b0;
      wait_valid(lat);
      check("drain_next_latency", lat, 32'd3);
      check("drain_next_data", {16'd0, out_data}, 32'd15);
      tick();
      wait_idle();
      // reset mid-RUN
      accept(16'd4, 16'd4, 16'd4);
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_st", {31'd0, root_st}, 32'd0);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      check("mid_rst_in0", {16'd0, root_in0}, 32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      check("mid_rst_ready_back", {31'd0, in_ready}, 32'd1);
      accept(16'd9, 16'd0, 16'd0);
      in_valid = 1'b0;
      wait_valid(lat);
      check("mid_rst_data", {16'd0, out_data}, 32'd9);
      tick();
      wait_idle();
`ifdef ROOT_DRIVER_TIMEOUT_EN
      // watchdog abort
      never = 1'b1;
      accept(16'd1, 16'd1, 16'd1);
      in_valid = 1'b0;
      wait_valid(lat);
      check("to_latency", lat, 32'd8);
      check("to_valid", {31'd0, out_valid}, 32'd1);
      check("to_flag", {31'd0, out_timeout}, 32'd1);
      check("to_data", {16'd0, out_data}, 32'd0);
      tick();
      check("to_released", {31'd0, out_valid}, 32'd0);
      check("to_flag_clr", {31'd0, out_timeout}, 32'd0);
      check("to_ready_back", {31'd0, in_ready}, 32'd1);
      never = 1'b0;
`endif
      // overlap: valid held high across four triples
      for (int t = 0; t < 4; t++) begin
         accept(W'(t * 10 + 1), W'(t), W'(100));
         wait_valid(lat);
         if (out_valid) nres++;
         check("ovl_data", {16'd0, out_data}, 32'(t * 11 + 101));
      end
      in_valid = 1'b0;
      tick();
      wait_idle();
      check("ovl_count", nres, 32'd4);
      check("ovl_st_vs_rd", viol, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end
endmodule
